// File: rtl/digital_input_loader_pkg.sv
// Shared slot codes, control-state encoding and sizing for the switch/button operand loader.
package digital_input_loader_pkg;

  localparam int unsigned NUM_SLOTS = 9;

  typedef enum logic [3:0] {
    SLOT_A0     = 4'd0,
    SLOT_A1     = 4'd1,
    SLOT_A2     = 4'd2,
    SLOT_A3     = 4'd3,
    SLOT_B0     = 4'd4,
    SLOT_B1     = 4'd5,
    SLOT_B2     = 4'd6,
    SLOT_B3     = 4'd7,
    SLOT_OP     = 4'd8,
    SLOT_COMMIT = 4'd9
  } slot_e;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_e;

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchronizer and stability counter for one raw push-button.
// Any board button can reuse this block.
module btn_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_0;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  // The level change is accepted on the edge after DEBOUNCE_CYCLES differing
  // cycles have been counted, i.e. DEBOUNCE_CYCLES+2 edges after the raw
  // input is first sampled high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_0     <= 1'b0;
      sync_q     <= 1'b0;
      cnt        <= '0;
      btn_level  <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_0     <= btn_raw;
      sync_q     <= sync_0;
      rise_pulse <= 1'b0;
      if (sync_q == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LIMIT) begin
        btn_level  <= ~btn_level;
        rise_pulse <= ~btn_level;
        cnt        <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/digital_input_loader.sv
// Assembles two 32-bit ALU operands and a 4-bit opcode from slide switches,
// one byte/field per debounced press, and commits them with a start pulse.
module digital_input_loader
  import digital_input_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DATA_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           switch_data,
  input  logic [3:0]           choose_target,
  input  logic                 load_btn,
  output logic [DATA_W-1:0]    operand_a,
  output logic [DATA_W-1:0]    operand_b,
  output logic [3:0]           alu_op,
  output logic                 start,
  output logic [NUM_SLOTS-1:0] loaded_mask,
  output logic                 btn_level
);

  logic              rise_pulse;
  logic              load_evt;
  state_e            state;
  logic [DATA_W-1:0] stg_a;
  logic [DATA_W-1:0] stg_b;
  logic [3:0]        stg_op;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (load_btn),
    .btn_level (btn_level),
    .rise_pulse(rise_pulse)
  );

  // One load event per press: leaving HELD requires the debounced level to fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      load_evt <= 1'b0;
    end else begin
      load_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_pulse) begin
            load_evt <= 1'b1;
            state    <= HELD;
          end
        end
        HELD: begin
          if (!btn_level) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_a       <= '0;
      stg_b       <= '0;
      stg_op      <= '0;
      operand_a   <= '0;
      operand_b   <= '0;
      alu_op      <= '0;
      start       <= 1'b0;
      loaded_mask <= '0;
    end else begin
      start <= 1'b0;
      if (load_evt) begin
        case (choose_target)
          SLOT_A0, SLOT_A1, SLOT_A2, SLOT_A3: begin
            stg_a[8*choose_target[1:0] +: 8] <= switch_data;
            loaded_mask[choose_target]       <= 1'b1;
          end
          SLOT_B0, SLOT_B1, SLOT_B2, SLOT_B3: begin
            stg_b[8*choose_target[1:0] +: 8] <= switch_data;
            loaded_mask[choose_target]       <= 1'b1;
          end
          SLOT_OP: begin
            stg_op         <= switch_data[3:0];
            loaded_mask[8] <= 1'b1;
          end
          SLOT_COMMIT: begin
            operand_a   <= stg_a;
            operand_b   <= stg_b;
            alu_op      <= stg_op;
            start       <= 1'b1;
            loaded_mask <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_digital_input_loader.sv
// Directed self-checking bench for digital_input_loader with DEBOUNCE_CYCLES=4.
module tb_digital_input_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  switch_data;
  logic [3:0]  choose_target;
  logic        load_btn;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_op;
  logic        start;
  logic [8:0]  loaded_mask;
  logic        btn_level;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned start_cnt = 0;
  int unsigned s0;
  logic [4:0]  pat;

  always #5 clk = ~clk;

  digital_input_loader #(
    .DEBOUNCE_CYCLES(4),
    .DATA_W         (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .switch_data  (switch_data),
    .choose_target(choose_target),
    .load_btn     (load_btn),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .alu_op       (alu_op),
    .start        (start),
    .loaded_mask  (loaded_mask),
    .btn_level    (btn_level)
  );

  // Counts cycles in which start is high, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (start === 1'b1) start_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] tgt, input logic [7:0] data, input int unsigned hold);
    choose_target = tgt;
    switch_data   = data;
    load_btn      = 1'b1;
    repeat (hold) @(negedge clk);
    load_btn = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    switch_data = '0;
    choose_target = '0;
    load_btn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state and quiet idle
    chk("rst_operand_a", operand_a, 32'h0);
    chk("rst_operand_b", operand_b, 32'h0);
    chk("rst_alu_op", {28'h0, alu_op}, 32'h0);
    chk("rst_start", {31'h0, start}, 32'h0);
    chk("rst_mask", {23'h0, loaded_mask}, 32'h0);
    chk("rst_btn_level", {31'h0, btn_level}, 32'h0);
    repeat (100) @(negedge clk);
    chk("idle_no_start", start_cnt, 32'd0);

    // Edge-accurate press: load_btn first sampled at edge 0
    choose_target = 4'd0;
    switch_data   = 8'h78;
    load_btn      = 1'b1;
    repeat (6) @(negedge clk);
    chk("lat_level_edge5", {31'h0, btn_level}, 32'h0);
    @(negedge clk);
    chk("lat_level_edge6", {31'h0, btn_level}, 32'h1);
    @(negedge clk);
    chk("lat_mask_edge7", {23'h0, loaded_mask}, 32'h0);
    @(negedge clk);
    chk("lat_mask_edge8", {23'h0, loaded_mask}, 32'h001);
    chk("lat_opa_unchanged", operand_a, 32'h0);
    repeat (4) @(negedge clk);
    load_btn = 1'b0;
    repeat (14) @(negedge clk);

    // Fill remaining slots
    press(4'd1, 8'h56, 12);
    press(4'd2, 8'h34, 12);
    press(4'd3, 8'h12, 12);
    press(4'd4, 8'h0F, 12);
    press(4'd5, 8'h00, 12);
    press(4'd6, 8'h00, 12);
    press(4'd7, 8'h00, 12);
    press(4'd8, 8'hA2, 12);
    chk("mask_full", {23'h0, loaded_mask}, 32'h1FF);
    chk("opa_before_commit", operand_a, 32'h0);
    press(4'd12, 8'hEE, 12);
    chk("noop_slot_mask", {23'h0, loaded_mask}, 32'h1FF);

    // Commit, edge-accurate
    s0 = start_cnt;
    choose_target = 4'd9;
    load_btn = 1'b1;
    repeat (8) @(negedge clk);
    chk("commit_start_edge7", {31'h0, start}, 32'h0);
    chk("commit_opa_edge7", operand_a, 32'h0);
    @(negedge clk);
    chk("commit_start_edge8", {31'h0, start}, 32'h1);
    chk("commit_opa", operand_a, 32'h12345678);
    chk("commit_opb", operand_b, 32'h0000000F);
    chk("commit_alu_op", {28'h0, alu_op}, 32'h2);
    chk("commit_mask_clr", {23'h0, loaded_mask}, 32'h0);
    @(negedge clk);
    chk("commit_start_edge9", {31'h0, start}, 32'h0);
    repeat (3) @(negedge clk);
    load_btn = 1'b0;
    repeat (14) @(negedge clk);
    chk("commit_one_start", start_cnt - s0, 32'd1);

    // Bounce: glitches alone are rejected
    s0 = start_cnt;
    pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      load_btn = pat[i];
      @(negedge clk);
    end
    load_btn = 1'b0;
    repeat (15) @(negedge clk);
    chk("glitch_no_start", start_cnt - s0, 32'd0);
    chk("glitch_level_low", {31'h0, btn_level}, 32'h0);

    // Bounce followed by a steady hold gives one event
    for (int i = 0; i < 5; i++) begin
      load_btn = pat[i];
      @(negedge clk);
    end
    load_btn = 1'b1;
    repeat (10) @(negedge clk);
    load_btn = 1'b0;
    repeat (14) @(negedge clk);
    chk("bounce_one_start", start_cnt - s0, 32'd1);
    chk("bounce_opa", operand_a, 32'h12345678);

    // Long hold on commit, then re-press
    s0 = start_cnt;
    press(4'd9, 8'h00, 200);
    chk("hold_one_start", start_cnt - s0, 32'd1);
    press(4'd9, 8'h00, 12);
    chk("repress_second_start", start_cnt - s0, 32'd2);
    chk("repress_opa", operand_a, 32'h12345678);
    chk("repress_opb", operand_b, 32'h0000000F);
    chk("repress_alu_op", {28'h0, alu_op}, 32'h2);

    // Reset during a held press
    choose_target = 4'd0;
    switch_data   = 8'hFF;
    load_btn      = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_mask_pre", {23'h0, loaded_mask}, 32'h001);
    chk("midrst_level_pre", {31'h0, btn_level}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_opa", operand_a, 32'h0);
    chk("midrst_opb", operand_b, 32'h0);
    chk("midrst_alu_op", {28'h0, alu_op}, 32'h0);
    chk("midrst_mask", {23'h0, loaded_mask}, 32'h0);
    chk("midrst_level", {31'h0, btn_level}, 32'h0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("postrst_fresh_load", {23'h0, loaded_mask}, 32'h001);
    chk("postrst_opa", operand_a, 32'h0);
    load_btn = 1'b0;
    repeat (14) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
